// File: rtl/vec_mem_pkg.sv
// Shared defaults and FSM state type for the vector memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_mem_pkg;

    localparam int WIDTH_DEF     = 24;  // data/address width of the shared memory port
    localparam int LANES_DEF     = 8;   // maximum elements per vector command
    localparam int STALL_MAX_DEF = 4;   // scalar wins in a row before the vector is forced on

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Bundle of command, response, scalar-request and memory-port signals.
// Latency: n/a (wires only).
// Backpressure: cmd_ready/cmd_valid handshake; sc_gnt holds off the scalar pipeline.
// Ports: slave = sequencer side, master = command source / scalar pipe / memory side.
interface vec_mem_sequencer_if
    import vec_mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF
);
    // vector command
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_store;
    logic [WIDTH-1:0]       cmd_base;
    logic [3:0]             cmd_len;
    logic [LANES*WIDTH-1:0] cmd_wdata;
    // completion
    logic                   rsp_valid;
    logic [LANES*WIDTH-1:0] rsp_rdata;
    // scalar pipeline access
    logic                   sc_req;
    logic                   sc_we;
    logic [WIDTH-1:0]       sc_addr;
    logic [WIDTH-1:0]       sc_wdata;
    logic                   sc_gnt;
    logic [WIDTH-1:0]       sc_rdata;
    // shared data memory port
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_addr;
    logic [WIDTH-1:0]       mem_wd;
    logic [WIDTH-1:0]       mem_rd;

    modport slave (
        input  cmd_valid, cmd_store, cmd_base, cmd_len, cmd_wdata,
        input  sc_req, sc_we, sc_addr, sc_wdata,
        input  mem_rd,
        output cmd_ready, rsp_valid, rsp_rdata,
        output sc_gnt, sc_rdata,
        output mem_we, mem_addr, mem_wd
    );

    modport master (
        output cmd_valid, cmd_store, cmd_base, cmd_len, cmd_wdata,
        output sc_req, sc_we, sc_addr, sc_wdata,
        output mem_rd,
        input  cmd_ready, rsp_valid, rsp_rdata,
        input  sc_gnt, sc_rdata,
        input  mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/vec_lane_buffer.sv
// LANES x WIDTH load-result buffer with per-lane write and synchronous clear.
// Latency: write visible on dat the cycle after the writing edge.
// Backpressure: none; writes are taken whenever we is high.
// Ports: clk, rst (sync, active-high), clr (sync clear), we/idx/wdat (lane write), dat (all lanes flat).
module vec_lane_buffer #(
    parameter int WIDTH = 24,
    parameter int LANES = 8,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [WIDTH-1:0]       wdat,
    output logic [LANES*WIDTH-1:0] dat
);

    logic [LANES*WIDTH-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dat_q <= '0;
        end else if (we) begin
            dat_q[idx*WIDTH +: WIDTH] <= wdat;
        end
    end

    assign dat = dat_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Sequences vector load/store commands over a memory port shared with a scalar pipeline.
// Latency: one port access per owned cycle; completion pulse the cycle after the last element (len 0: cycle after accept).
// Backpressure: cmd_ready only in IDLE; scalar wins unless it has starved the vector STALL_MAX cycles in a row.
// Ports: clk, rst (sync, active-high), bus (slave side of vec_mem_sequencer_if).
module vec_mem_sequencer
    import vec_mem_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    vec_mem_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(LANES + 1);
    localparam int STL_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);

    state_t                 state_q, state_d;
    logic                   store_q;
    logic [WIDTH-1:0]       base_q;
    logic [LANES*WIDTH-1:0] wdata_q;
    logic [IDX_W-1:0]       len_q;
    logic [IDX_W-1:0]       idx_q;
    logic [STL_W-1:0]       stall_q;

    logic                   accept;
    logic                   sc_own;
    logic                   vec_own;
    logic [IDX_W-1:0]       len_eff;
    logic [LANES*WIDTH-1:0] buf_dat;

    // Commands longer than the lane count are truncated rather than rejected.
    always_comb begin
        if (int'(bus.cmd_len) > LANES) begin
            len_eff = IDX_W'(LANES);
        end else begin
            len_eff = IDX_W'(bus.cmd_len);
        end
    end

    // Next state, port arbitration and all outputs.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        sc_own        = 1'b0;
        vec_own       = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wd    = '0;

        // Everything is gated by rst so an abandoned command cannot write in the reset cycle.
        if (!rst) begin
            bus.cmd_ready = (state_q == ST_IDLE);
            bus.rsp_valid = (state_q == ST_DONE);
            accept        = (state_q == ST_IDLE) && bus.cmd_valid;
            sc_own        = bus.sc_req && (stall_q < STL_W'(STALL_MAX));
            vec_own       = !sc_own && (state_q == ST_RUN);
        end

        if (sc_own) begin
            bus.mem_we   = bus.sc_we;
            bus.mem_addr = bus.sc_addr;
            bus.mem_wd   = bus.sc_wdata;
        end else if (vec_own) begin
            bus.mem_we   = store_q;
            bus.mem_addr = base_q + WIDTH'(idx_q);
            bus.mem_wd   = wdata_q[idx_q*WIDTH +: WIDTH];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (len_eff == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (vec_own && (idx_q == len_q - IDX_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sc_gnt    = sc_own;
    assign bus.sc_rdata  = bus.mem_rd;
    // The buffer is cleared on accept, so it doubles as the held response.
    assign bus.rsp_rdata = buf_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                store_q <= bus.cmd_store;
                base_q  <= bus.cmd_base;
                wdata_q <= bus.cmd_wdata;
                len_q   <= len_eff;
                idx_q   <= '0;
            end else if (vec_own) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            // sc_own already implies stall_q < STALL_MAX, so the count saturates there.
            if ((state_q != ST_RUN) || vec_own) begin
                stall_q <= '0;
            end else if (sc_own) begin
                stall_q <= stall_q + STL_W'(1);
            end
        end
    end

    vec_lane_buffer #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_lane_buffer (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .we   (vec_own && !store_q),
        .idx  (idx_q),
        .wdat (bus.mem_rd),
        .dat  (buf_dat)
    );

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: loads, stores, scalar contention, length edge cases, wrap, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_vec_mem_sequencer;
    import vec_mem_pkg::*;

    localparam int W = 24;
    localparam int L = 8;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    vec_mem_sequencer_if #(.WIDTH(W), .LANES(L)) bus();

    vec_mem_sequencer #(.WIDTH(W), .LANES(L), .STALL_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory returns its own address as read data.
    assign bus.mem_rd = bus.mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lanes 0..n-1 hold first, first+1, ...; higher lanes zero.
    function automatic logic [L*W-1:0] ramp(input int first, input int n);
        logic [L*W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*W +: W] = W'(first + i);
        return r;
    endfunction

    task automatic send(input logic st, input logic [W-1:0] base, input logic [3:0] len,
                        input logic [L*W-1:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_store = st;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        bus.cmd_wdata = wd;
        #1;
        chk("cmd_ready_at_accept", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0]   wrap_addr [4];
        logic [L*W-1:0] exp_v;
        int             cnt;
        int             guard;

        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_store = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = 4'd0;
        bus.cmd_wdata = '0;
        bus.sc_req    = 1'b1;
        bus.sc_we     = 1'b1;
        bus.sc_addr   = 24'h000007;
        bus.sc_wdata  = 24'h000009;

        // ---- reset state: everything quiet even with requests pending
        repeat (2) step();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_sc_gnt", bus.sc_gnt, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.sc_req    = 1'b0;
        #1;
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_mem_addr", bus.mem_addr, 0);

        // ---- scalar in IDLE owns the port
        bus.sc_req   = 1'b1;
        bus.sc_addr  = 24'h000123;
        bus.sc_wdata = 24'h000456;
        #1;
        chk("idle_sc_gnt", bus.sc_gnt, 1);
        chk("idle_sc_addr", bus.mem_addr, 24'h000123);
        chk("idle_sc_we", bus.mem_we, 1);
        chk("idle_sc_wd", bus.mem_wd, 24'h000456);
        chk("idle_sc_rdata", bus.sc_rdata, 24'h000123);
        bus.sc_req = 1'b0;
        bus.sc_we  = 1'b0;
        #1;
        chk("noown_mem_we", bus.mem_we, 0);
        chk("noown_mem_wd", bus.mem_wd, 0);
        step();

        // ---- load base 24 len 4
        send(1'b0, 24'd24, 4'd4, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ld_addr", bus.mem_addr, 24 + i);
            chk("ld_we", bus.mem_we, 0);
            chk("ld_rsp_early", bus.rsp_valid, 0);
            step();
        end
        #1;
        chk("ld_rsp_valid", bus.rsp_valid, 1);
        chk("ld_rdata", bus.rsp_rdata, ramp(24, 4));
        step();
        #1;
        chk("ld_rsp_pulse", bus.rsp_valid, 0);
        chk("ld_rdata_hold", bus.rsp_rdata, ramp(24, 4));
        chk("ld_back_idle", bus.cmd_ready, 1);
        step();

        // ---- store base 30 len 8, lane i = i+1
        send(1'b1, 24'd30, 4'd8, ramp(1, 8));
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("st_we", bus.mem_we, 1);
            chk("st_addr", bus.mem_addr, 30 + i);
            chk("st_wd", bus.mem_wd, i + 1);
            step();
        end
        #1;
        chk("st_rsp_valid", bus.rsp_valid, 1);
        chk("st_rdata_zero", bus.rsp_rdata, 0);
        chk("st_done_we", bus.mem_we, 0);
        step();

        // ---- load base 100 len 3 with scalar requesting every cycle
        bus.sc_req  = 1'b1;
        bus.sc_we   = 1'b0;
        bus.sc_addr = 24'h000555;
        bus.cmd_valid = 1'b1;
        bus.cmd_store = 1'b0;
        bus.cmd_base  = 24'd100;
        bus.cmd_len   = 4'd3;
        #1;
        chk("sc_gnt_at_accept", bus.sc_gnt, 1);
        chk("cmd_ready_contend", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            for (int s = 0; s < 4; s++) begin
                bus.sc_addr  = W'(24'h000500 + e * 4 + s);
                bus.sc_we    = (e == 1);
                bus.sc_wdata = W'(24'h00ABC0 + s);
                #1;
                chk("ct_sc_gnt", bus.sc_gnt, 1);
                chk("ct_sc_addr", bus.mem_addr, 24'h000500 + e * 4 + s);
                chk("ct_sc_rdata", bus.sc_rdata, 24'h000500 + e * 4 + s);
                chk("ct_sc_we", bus.mem_we, (e == 1));
                if (e == 1) chk("ct_sc_wd", bus.mem_wd, 24'h00ABC0 + s);
                step();
            end
            bus.sc_addr = 24'h000777;
            #1;
            chk("ct_vec_gnt", bus.sc_gnt, 0);
            chk("ct_vec_addr", bus.mem_addr, 100 + e);
            chk("ct_vec_we", bus.mem_we, 0);
            chk("ct_vec_rsp", bus.rsp_valid, 0);
            step();
        end
        #1;
        chk("ct_rsp_valid", bus.rsp_valid, 1);
        chk("ct_rdata", bus.rsp_rdata, ramp(100, 3));
        chk("ct_done_gnt", bus.sc_gnt, 1);
        bus.sc_req = 1'b0;
        bus.sc_we  = 1'b0;
        step();

        // ---- zero length: no access, response next cycle
        send(1'b1, 24'd55, 4'd0, '1);
        #1;
        chk("z_rsp_valid", bus.rsp_valid, 1);
        chk("z_mem_we", bus.mem_we, 0);
        chk("z_mem_addr", bus.mem_addr, 0);
        chk("z_rdata", bus.rsp_rdata, 0);
        step();
        #1;
        chk("z_rsp_pulse", bus.rsp_valid, 0);
        step();

        // ---- length 12 clamps to 8 accesses
        send(1'b0, 24'd200, 4'd12, '0);
        cnt   = 0;
        guard = 0;
        #1;
        while (!bus.rsp_valid && guard < 20) begin
            cnt++;
            guard++;
            step();
            #1;
        end
        chk("clamp_rsp_valid", bus.rsp_valid, 1);
        chk("clamp_accesses", cnt, 8);
        chk("clamp_rdata", bus.rsp_rdata, ramp(200, 8));
        step();

        // ---- address wraps at 2^24
        wrap_addr[0] = 24'hFFFFFE;
        wrap_addr[1] = 24'hFFFFFF;
        wrap_addr[2] = 24'h000000;
        wrap_addr[3] = 24'h000001;
        send(1'b0, 24'hFFFFFE, 4'd4, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wrap_addr", bus.mem_addr, wrap_addr[i]);
            step();
        end
        #1;
        exp_v = '0;
        for (int i = 0; i < 4; i++) exp_v[i*W +: W] = wrap_addr[i];
        chk("wrap_rsp_valid", bus.rsp_valid, 1);
        chk("wrap_rdata", bus.rsp_rdata, exp_v);
        step();

        // ---- reset on the third element of a len-8 store
        send(1'b1, 24'd300, 4'd8, ramp(1, 8));
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ab_we", bus.mem_we, 1);
            chk("ab_addr", bus.mem_addr, 300 + i);
            step();
        end
        rst = 1'b1;
        #1;
        chk("ab_rst_we", bus.mem_we, 0);
        chk("ab_rst_rsp", bus.rsp_valid, 0);
        chk("ab_rst_ready", bus.cmd_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("ab_ready", bus.cmd_ready, 1);
        chk("ab_addr_quiet", bus.mem_addr, 0);
        chk("ab_rdata_zero", bus.rsp_rdata, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("ab_no_rsp", bus.rsp_valid, 0);
            chk("ab_no_we", bus.mem_we, 0);
            chk("ab_still_idle", bus.cmd_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mem_sequencer.md
VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 24, data/address width of the shared memory port.
REQ-002 SHALL have parameter LANES, default 8, maximum elements per vector command.
REQ-003 SHALL have parameter STALL_MAX, default 4, consecutive vector stall cycles before the vector side is forced onto the port.
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk in 1, rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid in 1 command present; cmd_ready out 1 command accepted when both high.
REQ-007 cmd_store in 1 (1 = store, 0 = load); cmd_base in WIDTH first element address; cmd_len in 4 element count.
REQ-008 cmd_wdata  in  LANES*WIDTH  store data, lane i at bits [i*WIDTH +: WIDTH].
REQ-009 rsp_valid out 1 command-complete pulse; rsp_rdata out LANES*WIDTH load result.
REQ-010 sc_req in 1, sc_we in 1, sc_addr in WIDTH, sc_wdata in WIDTH: scalar pipeline access request.
REQ-011 sc_gnt out 1 scalar owns port this cycle; sc_rdata out WIDTH combinational read data.
REQ-012 mem_we out 1, mem_addr out WIDTH, mem_wd out WIDTH, mem_rd in WIDTH: data memory port (combinational read, write on clk edge).

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-014 IDLE: on cmd_valid, SHALL latch store flag, base, wdata, effective length (cmd_len clamped to LANES), clear element index and lane buffer, go RUN; effective length 0 goes directly to DONE with no memory access.
REQ-015 Port owner per cycle: scalar if sc_req and stall counter < STALL_MAX, else vector when in RUN, else nobody.
REQ-016 sc_gnt SHALL equal the scalar-owner condition; when sc_gnt = 0 the scalar pipeline holds its request.
REQ-017 Scalar owner: mem_addr = sc_addr, mem_wd = sc_wdata, mem_we = sc_we; sc_rdata = mem_rd always.
REQ-018 Vector owner: mem_addr = base + index (mod 2^WIDTH), mem_wd = latched lane[index], mem_we = store flag.
REQ-019 Vector load: SHALL capture mem_rd into buffer lane[index] at the clock edge of the owning cycle.
REQ-020 Index SHALL advance only in cycles the vector owns the port; after lane len-1 SHALL go DONE.
REQ-021 Stall counter SHALL increment in RUN when the scalar takes the port, reset to 0 when the vector owns the port or outside RUN, and saturate at STALL_MAX.
REQ-022 DONE: rsp_valid = 1 for exactly one cycle, rsp_rdata = buffer (lanes >= len are zero; all zero for stores), then IDLE.
REQ-023 rsp_rdata SHALL hold its value until the next command is accepted.
REQ-024 No owner: mem_we = 0, mem_addr = 0, mem_wd = 0.

Reset
REQ-025 While rst = 1: state IDLE, index 0, stall counter 0, buffer and rsp_rdata zero, rsp_valid 0, cmd_ready 0, sc_gnt 0, mem_we 0.
REQ-026 Reset mid-command SHALL abandon it with no further writes and no rsp_valid; cmd_ready returns high the first cycle after rst falls.

Structure
REQ-027 Package vec_mem_pkg SHALL hold WIDTH, LANES, STALL_MAX defaults and the state enum type.
REQ-028 Lane storage SHALL be sub-module vec_lane_buffer (LANES x WIDTH, per-lane write enable, synchronous clear); arbitration and FSM stay in vec_mem_sequencer.

Verification
REQ-029 Load, base 24, len 4, no scalar traffic, mem_rd = address -> addresses 24..27 on consecutive cycles, rsp_valid 5 cycles after accept, lanes 0..3 = 24..27, lanes 4..7 = 0.
REQ-030 Store, base 30, len 8, wdata lane i = i+1 -> mem_we high 8 cycles, mem_addr 30..37, mem_wd 1..8, rsp_rdata all zero.
REQ-031 Load len 3 with sc_req held high throughout -> sc_gnt 4 cycles, vector 1 cycle, repeating; command completes, scalar read data correct in granted cycles.
REQ-032 cmd_len 0 -> no mem_we and no vector address, rsp_valid one cycle after accept; cmd_len 12 -> exactly 8 accesses.
REQ-033 Base 2^24-2, len 4 -> addresses FFFFFE, FFFFFF, 000000, 000001.
REQ-034 rst asserted on 3rd element of a len-8 store -> no mem_we from the reset cycle onward, no rsp_valid, IDLE with cmd_ready = 1 one cycle after rst falls.
